// File: rtl/div_iter32.sv
`default_nettype none
// ============================================================================
// Module      : div_iter32 (with helper add_sub32)
// Description : Iterative 32-bit RV32M divider (DIV, DIVU, REM, REMU).
//               One add_sub32 instance performs every subtraction: the
//               divisor magnitude on the launch cycle, the dividend
//               magnitude in PREP, the trial subtraction in ITER and the
//               sign fix-up negation in FIX.
//               Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed
//               overflow short-circuit from PREP straight to DONE.
// Revision    : 1.0 - initial release
// ============================================================================

// 32-bit adder/subtractor: o_sum = i_a + i_b, or i_a - i_b when i_sub=1.
// o_cout is the carry out; on subtraction it is 1 when no borrow occurred.
module add_sub32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_sub,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [32:0] w_full;

    // Two's-complement subtraction as a + ~b + 1.
    assign w_full = {1'b0, i_a} + {1'b0, i_b ^ {32{i_sub}}} + {32'd0, i_sub};
    assign o_sum  = w_full[31:0];
    assign o_cout = w_full[32];
endmodule

module div_iter32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PREP = 3'd1;
    localparam logic [2:0] c_ITER = 3'd2;
    localparam logic [2:0] c_FIX  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    logic [1:0]  r_op;
    logic [31:0] r_a;          // dividend as launched (needed for sign and REM-by-zero)
    logic        r_b_neg;      // sign of the divisor as launched
    logic        r_b_zero;     // divisor was zero
    logic [31:0] r_divisor;    // divisor magnitude (signed ops) or raw divisor
    logic [31:0] r_rem;        // partial remainder; its 33rd bit only exists after the shift
    logic [31:0] r_quo;        // dividend bits shifting out, quotient bits shifting in
    logic [4:0]  r_cnt;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_signed_op;
    logic        w_is_rem;
    logic [32:0] w_rem_sh;
    logic        w_take;
    logic        w_neg_q;
    logic        w_neg_r;
    logic        w_fix_neg;
    logic        w_early;

    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic [31:0] w_add_sum;
    logic        w_add_cout;

    assign w_accept    = start && (r_state == c_IDLE || r_state == c_DONE);
    assign w_signed_op = ~r_op[0];
    assign w_is_rem    = r_op[1];
    assign w_rem_sh    = {r_rem, r_quo[31]};
    // Accept the trial when the shifted remainder overflowed 32 bits or no borrow.
    assign w_take      = w_rem_sh[32] | w_add_cout;

    // Quotient of a divide-by-zero stays all ones regardless of operand signs.
    assign w_neg_q   = w_signed_op & (r_a[31] ^ r_b_neg) & ~r_b_zero;
    assign w_neg_r   = w_signed_op & r_a[31];
    assign w_fix_neg = w_is_rem ? w_neg_r : w_neg_q;

`ifdef DIV_EARLY_OUT_EN
    logic        w_ovf;
    logic [31:0] w_early_result;

    // b == -1 is seen as a negative divisor of magnitude one.
    assign w_ovf   = w_signed_op & (r_a == 32'h8000_0000) & r_b_neg & (r_divisor == 32'd1);
    assign w_early = r_b_zero | w_ovf;
    assign w_early_result = r_b_zero ? (w_is_rem ? r_a   : 32'hFFFF_FFFF)
                                     : (w_is_rem ? 32'd0 : 32'h8000_0000);
`else
    assign w_early = 1'b0;
`endif

    add_sub32 u_add_sub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_sub  (1'b1),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // Steer the shared subtractor operands according to the current phase.
    always_comb begin
        w_add_a = 32'd0;
        w_add_b = 32'd0;
        case (r_state)
            c_IDLE, c_DONE: w_add_b = b;
            c_PREP:         w_add_b = r_a;
            c_ITER: begin
                w_add_a = w_rem_sh[31:0];
                w_add_b = r_divisor;
            end
            c_FIX:          w_add_b = w_is_rem ? r_rem : r_quo;
            default: begin
                w_add_a = 32'd0;
                w_add_b = 32'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_IDLE: if (start) w_next_state = c_PREP;
            c_PREP: begin
                busy         = 1'b1;
                w_next_state = w_early ? c_DONE : c_ITER;
            end
            c_ITER: begin
                busy = 1'b1;
                if (r_cnt == 5'd0) w_next_state = c_FIX;
            end
            c_FIX: begin
                busy         = 1'b1;
                w_next_state = c_DONE;
            end
            c_DONE: begin
                done         = 1'b1;
                w_next_state = start ? c_PREP : c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Operand capture, shift/subtract iterations and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= 2'd0;
            r_a       <= 32'd0;
            r_b_neg   <= 1'b0;
            r_b_zero  <= 1'b0;
            r_divisor <= 32'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_cnt     <= 5'd0;
            r_result  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op      <= op;
                r_a       <= a;
                r_b_neg   <= b[31];
                r_b_zero  <= (b == 32'd0);
                r_divisor <= (~op[0] & b[31]) ? w_add_sum : b;
            end
            case (r_state)
                c_PREP: begin
                    r_quo <= (w_signed_op & r_a[31]) ? w_add_sum : r_a;
                    r_rem <= 32'd0;
                    r_cnt <= 5'd31;
`ifdef DIV_EARLY_OUT_EN
                    if (w_early) r_result <= w_early_result;
`endif
                end
                c_ITER: begin
                    r_quo <= {r_quo[30:0], w_take};
                    r_rem <= w_take ? w_add_sum : w_rem_sh[31:0];
                    r_cnt <= r_cnt - 5'd1;
                end
                c_FIX: begin
                    r_result <= w_fix_neg ? w_add_sum : (w_is_rem ? r_rem : r_quo);
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_div_iter32.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter32
// Description : Scoreboard bench for div_iter32. Directed operations push
//               their expected result and done cycle; a monitor pops and
//               compares whenever done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter32;
    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_DIVU = 2'b01;
    localparam logic [1:0] c_REM  = 2'b10;
    localparam logic [1:0] c_REMU = 2'b11;
    localparam int         c_LAT_NORMAL = 35;
`ifdef DIV_EARLY_OUT_EN
    localparam int         c_LAT_SPECIAL = 2;
`else
    localparam int         c_LAT_SPECIAL = 35;
`endif

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    div_iter32 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 result=%h (cycle %0d)", result, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", result, mon_e.res);
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Called at a negedge: drive one start pulse and record the expectation.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp);
        int lat;
        lat   = is_special(o, x, y) ? c_LAT_SPECIAL : c_LAT_NORMAL;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back('{res: exp, cyc: cyc + lat});
        @(negedge clk);
        start = 1'b0;
        chk("busy_cycle1", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0 pending results", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp);
        launch(o, x, y, exp);
        drain();
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);

        // Basic unsigned and signed cases.
        run(c_DIVU, 32'd100, 32'd7, 32'd14);
        run(c_REMU, 32'd100, 32'd7, 32'd2);
        run(c_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run(c_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run(c_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run(c_REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
        run(c_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3);
        run(c_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run(c_DIVU, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA);
        run(c_REMU, 32'h8000_0000, 32'd3, 32'd2);
        run(c_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

        // Divide by zero.
        run(c_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
        run(c_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run(c_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run(c_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run(c_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);

        // Signed overflow.
        run(c_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run(c_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // start while busy is ignored; start in the DONE cycle is accepted.
        t0 = cyc;
        launch(c_DIVU, 32'd100, 32'd7, 32'd14);
        while (cyc < t0 + 10) @(negedge clk);
        start = 1'b1;
        op    = c_DIV;
        a     = 32'd1000;
        b     = 32'd10;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 35) @(negedge clk);
        launch(c_DIV, 32'd1000, 32'd10, 32'd100);
        drain();

        // Reset in the middle of an operation.
        t0 = cyc;
        launch(c_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
        while (cyc < t0 + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        run(c_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);

        repeat (40) @(negedge clk);
        chk("no_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
